piso_dir_tx: RTL

Parallel-in, serial-out transmitter with selectable shift direction. It is the transmit-side counterpart of the team's serial-in, parallel-out receive registers. It accepts a WIDTH-bit word through a valid/ready load handshake and emits it one bit per enabled cycle, MSB-first or LSB-first. It supports back-to-back frames with no idle gap and an external bit-rate enable for pacing.

---
 rtl/piso_dir_tx.sv | 83 ++++++++
 1 files changed

// File: rtl/piso_dir_tx.sv
// Parallel-in, serial-out transmitter with per-frame shift direction,
// valid/ready word loading, bit-rate enable pacing and back-to-back frames.
module piso_dir_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             shift_en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             dir,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             last,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dir_q;
  logic             cnt_zero;

  assign cnt_zero = (cnt_q == '0);

  // The final-bit edge of a frame doubles as the acceptance edge of the
  // next word, which is what makes gapless back-to-back frames possible.
  assign load_ready = (state_q == IDLE) || (cnt_zero && shift_en);

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values and the update order inside the block is irrelevant.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_valid) begin
            state_q <= SHIFT;
            sreg_q  <= data_in;
            dir_q   <= dir;
            cnt_q   <= CNT_MAX;
          end
        end
        SHIFT: begin
          if (shift_en) begin
            if (!cnt_zero) begin
              sreg_q <= dir_q ? {1'b0, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], 1'b0};
              cnt_q  <= cnt_q - CNT_W'(1);
            end else if (load_valid) begin
              sreg_q <= data_in;
              dir_q  <= dir;
              cnt_q  <= CNT_MAX;
            end else begin
              state_q <= IDLE;
              sreg_q  <= '0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Serial-side outputs are pure decodes of registered state.
  assign serial_valid = (state_q == SHIFT);
  assign busy         = serial_valid;
  assign last         = serial_valid && cnt_zero;
  assign serial_out   = serial_valid && (dir_q ? sreg_q[0] : sreg_q[WIDTH-1]);

endmodule
